vram_rect_writer: RTL and testbench
===================================

Name: vram_rect_writer

Overview:
- Write-side engine for the 1-bit-per-pixel VRAM planes (128-pixel rows, 14-bit address, address = y*128 + x).
- Accepts a rectangle-fill command over a valid/ready handshake and emits one pixel write per clock, row-major, on a BRAM-style port: address, write enable, data.
- Clips to the visible area.
- Sits between the drawing/game logic and the write port of one colour plane. One instance per plane, or one shared instance muxed by the caller.

Parameters:
- H_PIX, 128, visible pixels per row; must equal 2**X_W.
- V_PIX, 96, visible rows; must be ≤ 2**Y_W.
- X_W, 7, column index width.
- Y_W, 7, row index width; ADDR_W = X_W + Y_W = 14.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  7  left column.
- cmd_y0  in  7  top row.
- cmd_w  in  8  width in pixels (0..255).
- cmd_h  in  8  height in rows (0..255).
- cmd_color  in  1  bit value written to every pixel.
- vram_we  out  1  write strobe, one pixel per high cycle.
- vram_addr  out  14  write address {y, x}.
- vram_din  out  1  write data.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - Outputs: cmd_ready=0 while asserted, vram_we=0, vram_addr=0, vram_din=0, busy=0, done=0.
  - Internal counters clear.
- First rising edge with reset=1: cmd_ready=1.
- Acceptance:
  - A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
  - All cmd_* fields are registered at that edge; later changes are ignored.
  - cmd_ready is 1 only in IDLE. It drops the cycle after acceptance and returns the cycle after the done pulse.
  - cmd_valid while not ready is ignored, not queued.
- FSM states: IDLE, CLIP, FILL, DONE.
  - IDLE → CLIP on acceptance; busy=1 from the next cycle.
  - CLIP, one cycle:
    - x_end = min(x0+w, H_PIX), computed 9-bit.
    - y_end = min(y0+h, V_PIX), computed 9-bit.
    - Empty if w=0, h=0, x0 ≥ H_PIX or y0 ≥ V_PIX.
    - Empty → DONE; else → FILL with x=x0, y=y0.
  - FILL, one write per cycle:
    - vram_we=1, vram_addr={y[6:0], x[6:0]}, vram_din=color.
    - Next x: if x+1 == x_end then x=x0, y=y+1; else x=x+1.
    - After the write at (x_end-1, y_end-1) → DONE.
  - DONE, one cycle: done=1, busy=0, vram_we=0; → IDLE.
- Latency and cycle counts:
  - First vram_we cycle starts 2 edges after the acceptance edge.
  - Writes are continuous, never gapped.
  - Write count = (x_end-x0)*(y_end-y0).
  - done asserts the cycle after the last write.
  - Empty command: done 2 cycles after acceptance, zero writes.
- Output registering:
  - vram_addr and vram_din are registered.
  - Outside FILL they hold their last value; only vram_we qualifies them.
- Arithmetic:
  - No address wrap; clipping prevents x or y overflow.
  - Pixels with y ≥ V_PIX are never written even though the address space extends to 127.
- Reset mid-operation: writing stops immediately (async), no done pulse, the command is discarded.

Test Plan:
- Basic fill:
  - Reset, then cmd x0=10, y0=5, w=3, h=2, color=1.
  - Response: vram_we high 6 consecutive cycles starting 2 edges after acceptance.
  - vram_addr sequence 650, 651, 652, 778, 779, 780, vram_din=1 throughout.
  - done pulse on the next cycle; cmd_ready=1 the cycle after.
- Clipping:
  - Cmd x0=126, y0=95, w=4, h=3, color=0.
  - Response: exactly 2 writes, addresses 12286 and 12287, vram_din=0.
  - Then done; no address ≥ 12288 ever strobed.
- Empty commands:
  - Cmd w=0, then separately x0=0, y0=100, w=5, h=5.
  - Response: each gives zero vram_we cycles and a done pulse 2 cycles after acceptance.
- Full clear:
  - Cmd x0=0, y0=0, w=128, h=96, color=0.
  - Response: 12288 contiguous writes, addresses 0..12287 in order, busy high throughout, single done.
- Handshake:
  - Hold cmd_valid=1 with a second command while busy.
  - Response: cmd_ready=0 for the whole first fill. The second command is accepted only on the edge after DONE, then executes fully.
- Async reset mid-fill:
  - Assert reset=0 between clock edges during the 3rd write of the basic fill.
  - Response: vram_we, busy and done drop without waiting for a clock edge, and no done pulse occurs.
  - After release, cmd_ready=1 and a fresh command runs correctly.

Source files
------------

// File: rtl/vram_rect_writer.sv
// Rectangle-fill write engine for one 1-bpp VRAM plane.
// Accepts a command, clips it to the visible area, then emits one pixel write per clock, row-major.
module vram_rect_writer #(
  parameter int unsigned H_PIX = 128,
  parameter int unsigned V_PIX = 96,
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [7:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic               cmd_color,
  output logic               vram_we,
  output logic [X_W+Y_W-1:0] vram_addr,
  output logic               vram_din,
  output logic               busy,
  output logic               done
);

  localparam int unsigned E_W = 9;
  localparam logic [E_W-1:0] H_LIM = E_W'(H_PIX);
  localparam logic [E_W-1:0] V_LIM = E_W'(V_PIX);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_ready;
  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y0;
  logic [Y_W-1:0] r_y;
  logic [7:0]     r_w;
  logic [7:0]     r_h;
  logic           r_color;
  logic           r_din;
  logic [E_W-1:0] r_xend;
  logic [E_W-1:0] r_yend;

  logic           w_accept;
  logic [E_W-1:0] w_xsum;
  logic [E_W-1:0] w_ysum;
  logic [E_W-1:0] w_xend;
  logic [E_W-1:0] w_yend;
  logic           w_empty;
  logic           w_row_end;
  logic           w_last;

  assign w_accept  = cmd_valid & r_ready;
  assign w_xsum    = E_W'(r_x0) + E_W'(r_w);
  assign w_ysum    = E_W'(r_y0) + E_W'(r_h);
  assign w_xend    = (w_xsum > H_LIM) ? H_LIM : w_xsum;
  assign w_yend    = (w_ysum > V_LIM) ? V_LIM : w_ysum;
  assign w_empty   = (r_w == '0) || (r_h == '0) || (E_W'(r_x0) >= H_LIM) || (E_W'(r_y0) >= V_LIM);
  assign w_row_end = (E_W'(r_x) + E_W'(1)) == r_xend;
  assign w_last    = w_row_end && ((E_W'(r_y) + E_W'(1)) == r_yend);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLIP;
      S_CLIP:  w_next = w_empty ? S_DONE : S_FILL;
      S_FILL:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ready is registered so it stays low while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_din   <= 1'b0;
      r_xend  <= '0;
      r_yend  <= '0;
    end else begin
      if (w_accept) begin
        r_x0    <= cmd_x0;
        r_y0    <= cmd_y0;
        r_w     <= cmd_w;
        r_h     <= cmd_h;
        r_color <= cmd_color;
      end
      // Address/data registers only move for real writes so they hold their last value otherwise.
      case (r_state)
        S_CLIP: begin
          r_xend <= w_xend;
          r_yend <= w_yend;
          if (!w_empty) begin
            r_x   <= r_x0;
            r_y   <= r_y0;
            r_din <= r_color;
          end
        end
        S_FILL: begin
          if (!w_last) begin
            if (w_row_end) begin
              r_x <= r_x0;
              r_y <= r_y + Y_W'(1);
            end else begin
              r_x <= r_x + X_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign vram_we   = (r_state == S_FILL);
  assign busy      = (r_state == S_CLIP) || (r_state == S_FILL);
  assign done      = (r_state == S_DONE);
  assign vram_addr = {r_y, r_x};
  assign vram_din  = r_din;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Self-checking bench for vram_rect_writer: directed scenarios plus random rectangles
// compared against a pixel-list reference model.
module tb_vram_rect_writer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic        cmd_color;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic        vram_din;
  logic        busy;
  logic        done;

  int n_pass;
  int n_total;
  int exp_q[$];

  vram_rect_writer #(.H_PIX(128), .V_PIX(96), .X_W(7), .Y_W(7)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list every visible pixel of the rectangle in row-major order.
  task automatic build_expect(input int x0, input int y0, input int w, input int h);
    int xe;
    int ye;
    exp_q.delete();
    xe = (x0 + w > 128) ? 128 : x0 + w;
    ye = (y0 + h > 96) ? 96 : y0 + h;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++)
        exp_q.push_back(y * 128 + x);
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL %s ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
    else n_pass++;
  endtask

  // Issue one command and check the full response cycle by cycle.
  // With hold=1 the next command is presented immediately and cmd_valid stays high.
  task automatic run_cmd(input string name, input int x0, input int y0, input int w, input int h,
                         input bit c, input bit hold, input int nx0, input int ny0, input int nw,
                         input int nh, input bit nc);
    int n;
    int exp_done;
    build_expect(x0, y0, w, h);
    n = exp_q.size();
    exp_done = (n == 0) ? 2 : n + 2;
    wait_ready(name);
    cmd_valid = 1'b1;
    cmd_x0 = 7'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 8'(h); cmd_color = c;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      cmd_x0 = 7'(nx0); cmd_y0 = 7'(ny0); cmd_w = 8'(nw); cmd_h = 8'(nh); cmd_color = nc;
    end else begin
      cmd_valid = 1'b0;
      cmd_x0 = 7'($urandom); cmd_y0 = 7'($urandom); cmd_w = 8'($urandom); cmd_h = 8'($urandom);
      cmd_color = 1'($urandom);
    end
    n_total++;
    if (busy !== 1'b1 || vram_we !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL %s clip_cycle: busy=%b we=%b ready=%b done=%b required 1 0 0 0",
               name, busy, vram_we, cmd_ready, done);
    else n_pass++;
    for (int k = 2; k <= exp_done; k++) begin
      @(negedge clk);
      n_total++;
      if (vram_we !== (k <= n + 1) || done !== (k == exp_done) || busy !== (k != exp_done) ||
          cmd_ready !== 1'b0)
        $display("FAIL %s ctrl k=%0d: we=%b done=%b busy=%b ready=%b required %b %b %b 0", name, k,
                 vram_we, done, busy, cmd_ready, (k <= n + 1), (k == exp_done), (k != exp_done));
      else n_pass++;
      if (k <= n + 1) begin
        n_total++;
        if (vram_addr !== 14'(exp_q[k-2]) || vram_din !== c)
          $display("FAIL %s write %0d: addr=%0d din=%b required addr=%0d din=%b", name, k - 2,
                   vram_addr, vram_din, exp_q[k-2], c);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || vram_we !== 1'b0)
      $display("FAIL %s after_done: ready=%b done=%b busy=%b we=%b required 1 0 0 0",
               name, cmd_ready, done, busy, vram_we);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b0 || vram_we !== 1'b0 || vram_addr !== 14'd0 || vram_din !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: ready=%b we=%b addr=%0d din=%b busy=%b done=%b required all 0",
               cmd_ready, vram_we, vram_addr, vram_din, busy, done);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_cmd("basic", 10, 5, 3, 2, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_clip();
    run_cmd("clip", 126, 95, 4, 3, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    run_cmd("clip_wide", 120, 90, 255, 255, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_empty();
    run_cmd("empty_w0", 20, 20, 0, 5, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    run_cmd("empty_y100", 0, 100, 5, 5, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    run_cmd("empty_h0", 3, 3, 7, 0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_full_clear();
    run_cmd("full_clear", 0, 0, 128, 96, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("hs_first", 40, 30, 5, 3, 1'b1, 1'b1, 60, 10, 4, 2, 1'b0);
    run_cmd("hs_second", 60, 10, 4, 2, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    wait_ready("async");
    cmd_valid = 1'b1;
    cmd_x0 = 7'd10; cmd_y0 = 7'd5; cmd_w = 8'd3; cmd_h = 8'd2; cmd_color = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (vram_we !== 1'b1 || vram_addr !== 14'd652)
      $display("FAIL async_third_write: we=%b addr=%0d required 1 652", vram_we, vram_addr);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++;
    if (vram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL async_drop: we=%b busy=%b done=%b ready=%b required all 0",
               vram_we, busy, done, cmd_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || vram_we !== 1'b0)
        $display("FAIL async_no_done %0d: done=%b we=%b required 0 0", i, done, vram_we);
      else n_pass++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL async_release: ready=%b done=%b required 1 0", cmd_ready, done);
    else n_pass++;
    run_cmd("async_fresh", 2, 7, 4, 3, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int x0, y0, w, h;
    bit c;
    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(0, 127);
      y0 = $urandom_range(0, 110);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 20);
      h  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8);
      c  = 1'($urandom);
      run_cmd($sformatf("rand%0d", i), x0, y0, w, h, c, 1'b0, 0, 0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_full_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
